// File: rtl/cpu_controlunit.sv
// rtl/cpu_controlunit.sv - multi-cycle control sequencer for cpu_datapathunit
//
// Purpose:
//   Steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
//   FETCH and MEM wait for the memory handshake. Every datapath strobe is
//   a combinational decode of the state, the latched opcode/funct, zero
//   and mem_ack. HALT and illegal opcodes park the sequencer until reset.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   opcode     in   8   instr[7:0] from datapath
//   funct      in   8   instr[15:8], ALU function for reg-reg ops
//   zero       in   1   ALU zero flag
//   mem_ack    in   1   memory completion, one per request
//   fetch      out  1   instruction-read request, held until mem_ack
//   ir_write   out  1   instruction-register load strobe
//   pc_inc     out  1   PC += 4 strobe
//   pc_write   out  1   PC load from branch/jump target
//   jump, reg_dst, reg_write, mem_read, mem_write, memtoreg, beq, bne
//              out  1   datapath controls
//   alu_opcode out  16  ALU operation select
//   halted     out  1   HALT executed
//   illegal    out  1   illegal-opcode trap
//   state      out  3   current state, debug view

module cpu_controlunit #(
  parameter logic [15:0] ALU_ADD = 16'h0001,
  parameter logic [15:0] ALU_SUB = 16'h0002
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  opcode,
  input  logic [7:0]  funct,
  input  logic        zero,
  input  logic        mem_ack,
  output logic        fetch,
  output logic        ir_write,
  output logic        pc_inc,
  output logic        pc_write,
  output logic        jump,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        memtoreg,
  output logic        beq,
  output logic        bne,
  output logic [15:0] alu_opcode,
  output logic        halted,
  output logic        illegal,
  output logic [2:0]  state
);

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_ALU   = 8'h01;
  localparam logic [7:0] OP_LOAD  = 8'h02;
  localparam logic [7:0] OP_STORE = 8'h03;
  localparam logic [7:0] OP_BEQ   = 8'h04;
  localparam logic [7:0] OP_BNE   = 8'h05;
  localparam logic [7:0] OP_JMP   = 8'h06;
  localparam logic [7:0] OP_HALT  = 8'h07;

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] op_q, op_d;
  logic [7:0] funct_q, funct_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST;
      op_q    <= 8'h00;
      funct_q <= 8'h00;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      funct_q <= funct_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    funct_d    = funct_q;
    fetch      = 1'b0;
    ir_write   = 1'b0;
    pc_inc     = 1'b0;
    pc_write   = 1'b0;
    jump       = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    memtoreg   = 1'b0;
    beq        = 1'b0;
    bne        = 1'b0;
    alu_opcode = 16'h0000;
    halted     = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      S_RST: state_d = S_FETCH;

      S_FETCH: begin
        fetch = 1'b1;
        if (mem_ack) begin
          ir_write = 1'b1;
          pc_inc   = 1'b1;
          state_d  = S_DECODE;
        end
      end

      // Later states use only the latched copies, so the datapath may
      // change opcode/funct freely after this cycle.
      S_DECODE: begin
        op_d    = opcode;
        funct_d = funct;
        if (opcode == OP_NOP)       state_d = S_FETCH;
        else if (opcode == OP_HALT) state_d = S_HALT;
        else if (opcode > OP_HALT)  state_d = S_TRAP;
        else                        state_d = S_EXEC;
      end

      S_EXEC: begin
        case (op_q)
          OP_ALU: begin
            alu_opcode = {8'h00, funct_q};
            state_d    = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_opcode = ALU_ADD;
            state_d    = S_MEM;
          end
          OP_BEQ: begin
            beq        = 1'b1;
            alu_opcode = ALU_SUB;
            pc_write   = zero;
            state_d    = S_FETCH;
          end
          OP_BNE: begin
            bne        = 1'b1;
            alu_opcode = ALU_SUB;
            pc_write   = ~zero;
            state_d    = S_FETCH;
          end
          OP_JMP: begin
            jump     = 1'b1;
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end
          // NOP/HALT/illegal never reach EXEC; recover by refetching.
          default: state_d = S_FETCH;
        endcase
      end

      S_MEM: begin
        alu_opcode = ALU_ADD;
        if (op_q == OP_LOAD) mem_read  = 1'b1;
        else                 mem_write = 1'b1;
        if (mem_ack) state_d = (op_q == OP_LOAD) ? S_WB : S_FETCH;
      end

      S_WB: begin
        reg_write = 1'b1;
        if (op_q == OP_ALU) begin
          reg_dst    = 1'b1;
          alu_opcode = {8'h00, funct_q};
        end else begin
          memtoreg = 1'b1;
        end
        state_d = S_FETCH;
      end

      S_HALT: halted = 1'b1;

      S_TRAP: illegal = 1'b1;

      default: state_d = S_RST;
    endcase
  end

  assign state = state_q;

endmodule

// File: doc/cpu_controlunit.md
# cpu_controlunit

Multi-cycle control sequencer for `cpu_datapathunit`. It runs each instruction through fetch, decode, execute, memory and write-back states, stretching fetch and memory states until the memory handshake completes. It drives every datapath control strobe (jump, reg_dst, reg_write, mem_read, mem_write, memtoreg, beq, bne, alu_opcode) from the decoded opcode. It sits between the datapath's `opcode` output and the memory interface, and stops on HALT or on an illegal opcode.

## Interface
Parameters:
- ALU_ADD, 16'h0001, alu_opcode for address generation (LOAD/STORE)
- ALU_SUB, 16'h0002, alu_opcode for branch compare (BEQ/BNE)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  8  instr[7:0] from datapath
- funct  in  8  instr[15:8], ALU function field for ALU ops
- zero  in  1  ALU zero flag
- mem_ack  in  1  memory completion, one per request
- fetch  out  1  instruction-read request, held until mem_ack
- ir_write  out  1  instruction-register load strobe
- pc_inc  out  1  PC += 4 strobe
- pc_write  out  1  PC load from branch/jump target
- jump, reg_dst, reg_write, mem_read, mem_write, memtoreg, beq, bne  out  1 each  datapath controls
- alu_opcode  out  16  ALU operation select
- halted  out  1  HALT executed
- illegal  out  1  illegal-opcode trap
- state  out  3  current state, for debug

## Operation
- Opcodes: 00 NOP, 01 ALU (reg-reg), 02 LOAD, 03 STORE, 04 BEQ, 05 BNE, 06 JMP, 07 HALT. Opcodes 08–FF are illegal.
- State encoding: RST=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, TRAP=7.
- RST:
  - Entered asynchronously whenever rst_n is low.
  - All outputs 0.
  - Moves to FETCH on the first clock edge after rst_n goes high.
- FETCH:
  - fetch=1.
  - On mem_ack: ir_write=1 and pc_inc=1 in that same cycle, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Latch opcode and funct into internal registers (op_q, funct_q).
  - NOP goes to FETCH, HALT goes to HALT, an illegal opcode goes to TRAP, everything else goes to EXEC.
- EXEC:
  - ALU: alu_opcode={8'h00,funct_q}, then go to WB.
  - LOAD/STORE: alu_opcode=ALU_ADD, then go to MEM.
  - BEQ: beq=1, alu_opcode=ALU_SUB, pc_write=zero, then go to FETCH.
  - BNE: bne=1, alu_opcode=ALU_SUB, pc_write=~zero, then go to FETCH.
  - JMP: jump=1, pc_write=1, then go to FETCH.
- MEM:
  - alu_opcode=ALU_ADD. LOAD holds mem_read=1; STORE holds mem_write=1.
  - On mem_ack: LOAD goes to WB, STORE goes to FETCH.
- WB:
  - reg_write=1 for exactly one cycle, then go to FETCH.
  - ALU: reg_dst=1, memtoreg=0, alu_opcode={8'h00,funct_q} held.
  - LOAD: reg_dst=0, memtoreg=1.
- HALT: halted=1, all other outputs 0. Left only by reset.
- TRAP: illegal=1, all other outputs 0. Left only by reset.
- Outputs are combinational decodes of state, op_q, funct_q, zero and mem_ack. Any output not listed for a state is 0.
- mem_ack outside FETCH/MEM is ignored and causes no state change.
- Only one of fetch, mem_read and mem_write is ever high in a given cycle.

## Timing
- Cycles per instruction with mem_ack in the request cycle: NOP 2, BEQ/BNE/JMP 3, ALU 4, STORE 4, LOAD 5.
- Each wait cycle before mem_ack adds 1 cycle to the state that is waiting (FETCH or MEM).
- The first fetch is asserted 1 cycle after rst_n deasserts.
- Reset mid-instruction:
  - Outputs go to 0 immediately, with no clock needed.
  - A pending mem_read/mem_write is dropped, and no reg_write or pc_write is issued.
- Changes to opcode/funct after DECODE have no effect, because the latched copies are used.
- zero is sampled combinationally in the BEQ/BNE EXEC cycle only.

## Test plan
- Reset, then hold mem_ack=1 with opcode=01 and funct=3C → state sequence 0,1,2,3,5,1; alu_opcode=003C in EXEC and WB; reg_write=1 and reg_dst=1 only in WB.
- LOAD (02) with mem_ack delayed 3 cycles in MEM → mem_read high for 4 cycles; then WB with memtoreg=1, reg_dst=0; total 8 cycles.
- BEQ with zero=1, then BEQ with zero=0, then BNE with zero=0 → pc_write=1, 0, 1 respectively in EXEC; each instruction takes 3 cycles.
- opcode=07 → halted=1 held for 20 or more cycles with fetch=0; opcode=9A → illegal=1 likewise; pulsing rst_n low returns state to 0 and all outputs to 0.
- STORE with rst_n asserted mid-MEM → mem_write drops in the same cycle; after release the next request is fetch; no reg_write is observed.
- Spurious mem_ack pulses during DECODE and EXEC → no state skip and no extra ir_write.
